// File: rtl/clock_segment_decoder.sv
// Measures high/low times of a generated clock on refclk and emits run-length-merged
// {on, off, repeat} segment words. Define SEG_GLITCH_FILTER_EN to reject 1-cycle pulses.
module clock_segment_decoder #(
  parameter logic [47:0] IDLE_TIMEOUT = 48'd1000000,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic         refclk,
  input  logic         reset_n,
  input  logic         clk_in,
  input  logic         arm,
  output logic [127:0] seg_data,
  output logic         seg_valid,
  input  logic         seg_ready,
  output logic         toggler_echo,
  output logic         busy,
  output logic         done,
  output logic         overflow_err,
  output logic [31:0]  periods_seen
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FIRST,
    S_HIGH,
    S_LOW,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam logic [47:0] CNT_MAX = '1;
  localparam logic [31:0] REP_MAX = '1;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0]   arm_sync_q, arm_sync_d;
  logic                     clk_prev_q;
  logic [47:0]              hi_cnt_q, hi_cnt_d;
  logic [47:0]              lo_cnt_q, lo_cnt_d;
  logic [47:0]              h_on_q, h_on_d;
  logic [47:0]              h_off_q, h_off_d;
  logic [31:0]              h_rep_q, h_rep_d;
  logic [127:0]             seg_data_q, seg_data_d;
  logic                     seg_valid_q, seg_valid_d;
  logic                     toggler_q, toggler_d;
  logic                     done_q, done_d;
  logic                     ovf_q, ovf_d;
  logic [31:0]              periods_q, periods_d;

  logic        s_clk, s_arm, clk_rise, clk_fall;
  logic        close, flush, emit;
  logic [47:0] close_on, close_off;

  assign s_clk = clk_sync_q[SYNC_STAGES-1];
  assign s_arm = arm_sync_q[SYNC_STAGES-1];

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], clk_in};
    arm_sync_d = {arm_sync_q[SYNC_STAGES-2:0], arm};
  end

`ifdef SEG_GLITCH_FILTER_EN
  // Accepted level only follows s_clk after two equal consecutive samples.
  logic filt_q, filt_d;
  assign clk_rise = s_clk & clk_prev_q & ~filt_q;
  assign clk_fall = ~s_clk & ~clk_prev_q & filt_q;
  always_comb begin
    filt_d = filt_q;
    if (clk_rise || clk_fall) filt_d = s_clk;
  end
`else
  assign clk_rise = s_clk & ~clk_prev_q;
  assign clk_fall = ~s_clk & clk_prev_q;
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
    state_d     = state_q;
    hi_cnt_d    = hi_cnt_q;
    lo_cnt_d    = lo_cnt_q;
    h_on_d      = h_on_q;
    h_off_d     = h_off_q;
    h_rep_d     = h_rep_q;
    seg_data_d  = seg_data_q;
    seg_valid_d = seg_valid_q;
    toggler_d   = toggler_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    periods_d   = periods_q;
    close       = 1'b0;
    flush       = 1'b0;
    emit        = 1'b0;
    close_on    = hi_cnt_q;
    close_off   = lo_cnt_q;

    case (state_q)
      S_IDLE: begin
        hi_cnt_d  = '0;
        lo_cnt_d  = '0;
        toggler_d = 1'b0;
        if (s_arm) state_d = S_WAIT_FIRST;
      end
      S_WAIT_FIRST: begin
        if (clk_rise) begin
          toggler_d = ~toggler_q;
          hi_cnt_d  = 48'd1;
          state_d   = S_HIGH;
        end
      end
      S_HIGH: begin
        if (clk_fall) begin
          lo_cnt_d = 48'd1;
          state_d  = S_LOW;
        end else if (hi_cnt_q != CNT_MAX) begin
          hi_cnt_d = hi_cnt_q + 48'd1;
        end
      end
      S_LOW: begin
        if (clk_rise) begin
          close     = 1'b1;
          toggler_d = ~toggler_q;
          hi_cnt_d  = 48'd1;
          state_d   = S_HIGH;
        end else if (lo_cnt_q >= IDLE_TIMEOUT) begin
          close     = 1'b1;
          close_off = IDLE_TIMEOUT;
          state_d   = S_FLUSH;
        end else if (lo_cnt_q != CNT_MAX) begin
          lo_cnt_d = lo_cnt_q + 48'd1;
        end
      end
      // Timeout may need two words (old held + final period); the second goes out here.
      S_FLUSH: begin
        flush   = 1'b1;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    // Abort discards the run but leaves a pending output word for the consumer.
    if (!s_arm) begin
      state_d   = S_IDLE;
      hi_cnt_d  = '0;
      lo_cnt_d  = '0;
      h_on_d    = '0;
      h_off_d   = '0;
      h_rep_d   = '0;
      toggler_d = 1'b0;
      done_d    = 1'b0;
      ovf_d     = 1'b0;
      periods_d = '0;
      close     = 1'b0;
      flush     = 1'b0;
    end

    if (close) begin
      periods_d = periods_q + 32'd1;
      if (h_rep_q != 32'd0 && close_on == h_on_q && close_off == h_off_q && h_rep_q != REP_MAX) begin
        h_rep_d = h_rep_q + 32'd1;
      end else begin
        emit    = (h_rep_q != 32'd0);
        h_on_d  = close_on;
        h_off_d = close_off;
        h_rep_d = 32'd1;
      end
    end

    if (flush) begin
      emit    = (h_rep_q != 32'd0);
      h_on_d  = '0;
      h_off_d = '0;
      h_rep_d = '0;
    end

    if (seg_valid_q && seg_ready) seg_valid_d = 1'b0;
    if (emit) begin
      if (!seg_valid_q || seg_ready) begin
        seg_data_d  = {h_on_q, h_off_q, h_rep_q};
        seg_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // NOTE: registers update only with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      clk_sync_q  <= '0;
      arm_sync_q  <= '0;
      clk_prev_q  <= 1'b0;
      hi_cnt_q    <= '0;
      lo_cnt_q    <= '0;
      h_on_q      <= '0;
      h_off_q     <= '0;
      h_rep_q     <= '0;
      seg_data_q  <= '0;
      seg_valid_q <= 1'b0;
      toggler_q   <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      periods_q   <= '0;
`ifdef SEG_GLITCH_FILTER_EN
      filt_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      arm_sync_q  <= arm_sync_d;
      clk_prev_q  <= s_clk;
      hi_cnt_q    <= hi_cnt_d;
      lo_cnt_q    <= lo_cnt_d;
      h_on_q      <= h_on_d;
      h_off_q     <= h_off_d;
      h_rep_q     <= h_rep_d;
      seg_data_q  <= seg_data_d;
      seg_valid_q <= seg_valid_d;
      toggler_q   <= toggler_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      periods_q   <= periods_d;
`ifdef SEG_GLITCH_FILTER_EN
      filt_q      <= filt_d;
`endif
    end
  end

  assign seg_data     = seg_data_q;
  assign seg_valid    = seg_valid_q;
  assign toggler_echo = toggler_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = done_q;
  assign overflow_err = ovf_q;
  assign periods_seen = periods_q;

endmodule

// File: doc/clock_segment_decoder.md
Name: clock_segment_decoder

Overview:
- Receive-side counterpart to the FIFO-driven variable-frequency clock generator.
- Samples an incoming generated clock on refclk and measures each high time and low time.
- Run-length-merges identical periods and emits 128-bit segment words in the generator's list format: {on_counts[47:0], off_counts[47:0], repeat_counts[31:0]}. The PC pipe-out path reads these words to verify timing lists.
- Also drives the toggler echo that the generator uses for mistrigger detection.

Parameters:
- IDLE_TIMEOUT, 48'd1000000: consecutive low refclk cycles that end a run; must exceed the largest off_counts in use.
- SYNC_STAGES, 2: synchroniser depth on clk_in and arm (minimum 2).

Ports:
- refclk  in  1  Sampling clock; same source as the generator's refclk, so measurements are exact.
- reset_n  in  1  Asynchronous, active-low reset.
- clk_in  in  1  Generated clock under test; asynchronous.
- arm  in  1  Level. 1 = capture enabled. 0 = abort capture and return to idle.
- seg_data  out  128  Segment word {on, off, repeat}.
- seg_valid  out  1  seg_data valid; held until accepted.
- seg_ready  in  1  Consumer accepts seg_data when seg_valid & seg_ready.
- toggler_echo  out  1  Toggles once per accepted rising edge of clk_in.
- busy  out  1  1 outside S_IDLE and S_DONE.
- done  out  1  Sticky; run ended by timeout. Cleared when arm deasserts.
- overflow_err  out  1  Sticky; a segment was dropped because the output register was still full. Cleared when arm deasserts.
- periods_seen  out  32  Count of complete periods in the current run; wraps.

Behaviour:
- Reset values: all outputs 0, state S_IDLE, all counters 0.
- clk_in and arm each pass through a SYNC_STAGES flop chain. A rise is s_clk == 1 with the previous sample == 0. A fall is the reverse.

States:
- S_IDLE: counters cleared, toggler_echo = 0. When sync arm = 1, go to S_WAIT_FIRST.
- S_WAIT_FIRST: on a rise, toggle toggler_echo, set hi_cnt = 1, go to S_HIGH. Line low is not timed here; there is no timeout before the first edge.
- S_HIGH: hi_cnt increments each cycle while high. On a fall, set lo_cnt = 1 and go to S_LOW.
- S_LOW: lo_cnt increments each cycle.
  - On a rise, close the period (on = hi_cnt, off = lo_cnt), toggle toggler_echo, set hi_cnt = 1, go to S_HIGH.
  - If lo_cnt reaches IDLE_TIMEOUT, close the final period with off = IDLE_TIMEOUT, flush the held segment, set done, go to S_DONE.
- S_DONE: hold outputs. When arm = 0, go to S_IDLE.
- Any state: arm = 0 goes to S_IDLE next cycle.
  - The held segment is discarded, not flushed.
  - done and overflow_err clear.
  - A pending seg_valid stays asserted until accepted.

Period merge:
- The held segment (h_on, h_off, h_rep) is initially empty.
- If the closed period's {on, off} equals {h_on, h_off} and h_rep != 32'hFFFFFFFF, then h_rep += 1.
- Otherwise, emit the held segment if it is non-empty, then load {on, off, 1}.
- A retrigger-wait gap appears as a long off, not as repeat = 0. The decoder never emits repeat = 0.

Emission and widths:
- If seg_valid = 0, load seg_data and set seg_valid in the same cycle as the period close (1-cycle latency from the closing edge detect).
- If seg_valid = 1 and seg_ready = 0, drop the word and set overflow_err.
- If seg_valid = 1 and seg_ready = 1 in the same cycle as a new emit, load the new word and keep seg_valid = 1.
- hi_cnt and lo_cnt are 48 bits and saturate at all-ones.
- periods_seen increments on every closed period, including the timeout close.

Mistrigger echo:
- Edge-detect latency is SYNC_STAGES + 1 cycles. The echo is therefore valid at the generator's next rise whenever on + off > SYNC_STAGES + 1.

Optional Feature:
- SEG_GLITCH_FILTER_EN defined:
  - A level change is accepted only after the synchronised clk_in holds the new value for 2 consecutive cycles.
  - Detect latency grows by 1 cycle. hi_cnt and lo_cnt still start at 1 on the accepted edge and include the filtered cycle, so counts are unchanged for pulses of 2 or more cycles.
  - A 1-cycle pulse is ignored entirely.
- Undefined: no filter; single-cycle pulses are measured as on = 1 or off = 1.

Test Plan:
- Clean run: arm = 1; 5 periods of on = 3/off = 7, then 2 periods of on = 10/off = 10, then low; seg_ready = 1. Required: word {3, 7, 5}, then {10, IDLE_TIMEOUT, 1} is not merged, so the sequence is {3, 7, 5}, {10, 10, 1}, {10, IDLE_TIMEOUT, 1}; done = 1; periods_seen = 7.
- Echo: 4 rises of on = 4/off = 4. Required: toggler_echo = 1, 0, 1, 0 after each rise, each change SYNC_STAGES + 1 cycles after the edge; 0 in S_IDLE.
- Backpressure: seg_ready = 0; pattern on = 2/off = 2 ×1, on = 3/off = 3 ×1, on = 4/off = 4 ×1. Required: first word held stable, second emit dropped, overflow_err = 1. Drop arm: overflow_err = 0 and the pending word remains until seg_ready = 1.
- Abort: deassert arm mid-S_HIGH after 3 periods of on = 5/off = 5. Required: next cycle S_IDLE, no segment emitted, busy = 0, toggler_echo = 0.
- Async reset: pulse reset_n low mid-S_LOW. Required: all outputs 0 immediately, without waiting for refclk.
- Glitch (SEG_GLITCH_FILTER_EN): a 1-cycle high pulse inside off = 20. Required: single segment {on, 20, n}; without the macro, the period splits into extra segments containing on = 1.
